mii_rx_frame_checker: RTL and testbench

// - Receive-end MII monitor for the 10BASE-T1S DTE benches. Taps RX_CLK/RXD/RX_DV/RX_ER between PHY and RS.
// - Strips preamble and SFD, assembles nibbles into bytes (low nibble first) and checks FCS (CRC-32).
// - Reports per-frame length and error status, so benches can score what the far-end MAC/PLCA transmitted.

---
 rtl/ieee_p802_3_mii_pkg.sv | 29 ++
 rtl/crc32_nib.sv | 24 ++
 rtl/mii_rx_frame_checker.sv | 174 +++++++++++++++++
 tb/tb_mii_rx_frame_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ieee_p802_3_mii_pkg.sv
// Shared MII constants, receive FSM encoding and frame status payload.
// Used by the receive frame checker and the matching transmit generator.
package ieee_p802_3_mii_pkg;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

    localparam int unsigned RX_STATE_W = 3;

    typedef enum logic [RX_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DROP    = 3'd4
    } mii_rx_state_e;

    typedef struct packed {
        logic crc_err;
        logic align_err;
        logic rxer_seen;
        logic runt;
        logic too_long;
    } mii_rx_status_t;

endpackage

// File: rtl/crc32_nib.sv
// Reflected CRC-32 update over one nibble, LSB of the nibble first.
module crc32_nib
    import ieee_p802_3_mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (crc_v[0] ^ nib[i]) begin
                crc_v = (crc_v >> 1) ^ CRC_POLY;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/mii_rx_frame_checker.sv
// MII receive monitor: strips preamble/SFD, assembles bytes low nibble first,
// checks FCS residue and reports per-frame length and error status.
module mii_rx_frame_checker
    import ieee_p802_3_mii_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             RX_CLK,
    input  logic             reset_n,
    input  logic             RX_DV,
    input  logic             RX_ER,
    input  logic [3:0]       RXD,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_vld,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_err,
    output logic             align_err,
    output logic             rxer_seen,
    output logic             runt,
    output logic             too_long,
    output logic [LEN_W-1:0] frame_len,
    output logic             pre_err
);

    mii_rx_state_e  state_q, state_d;
    logic [31:0]    crc_q, crc_d, crc_upd;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic [3:0]     lo_nib_q, lo_nib_d;
    logic           rxer_q, rxer_d;

    logic [7:0]     rx_byte_d;
    logic           rx_byte_vld_d, frame_done_d, frame_ok_d, pre_err_d;
    logic [LEN_W-1:0] frame_len_d;
    mii_rx_status_t status_q, status_d;

    logic           end_frame, end_odd;

    crc32_nib u_crc32_nib (
        .crc_in  (crc_q),
        .nib     (RXD),
        .crc_out (crc_upd)
    );

    assign len_inc = (len_q == '1) ? len_q : len_q + LEN_W'(1);

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_d         = len_q;
        lo_nib_d      = lo_nib_q;
        rxer_d        = rxer_q;
        rx_byte_d     = rx_byte;
        rx_byte_vld_d = 1'b0;
        frame_done_d  = 1'b0;
        pre_err_d     = 1'b0;
        frame_ok_d    = frame_ok;
        frame_len_d   = frame_len;
        status_d      = status_q;
        end_frame     = 1'b0;
        end_odd       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_DV) begin
                    if (RXD == PREAMBLE_NIB) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d   = ST_DROP;
                        pre_err_d = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!RX_DV) begin
                    state_d   = ST_IDLE;
                    pre_err_d = 1'b1;
                end else if (RXD == SFD_NIB) begin
                    state_d = ST_DATA_LO;
                    crc_d   = CRC_INIT;
                    len_d   = '0;
                    rxer_d  = 1'b0;
                end else if (RXD != PREAMBLE_NIB) begin
                    state_d   = ST_DROP;
                    pre_err_d = 1'b1;
                end
            end
            ST_DATA_LO: begin
                if (!RX_DV) begin
                    end_frame = 1'b1;
                end else begin
                    state_d  = ST_DATA_HI;
                    lo_nib_d = RXD;
                    crc_d    = crc_upd;
                    rxer_d   = rxer_q | RX_ER;
                end
            end
            ST_DATA_HI: begin
                if (!RX_DV) begin
                    end_frame = 1'b1;
                    end_odd   = 1'b1;
                end else begin
                    state_d       = ST_DATA_LO;
                    rx_byte_d     = {RXD, lo_nib_q};
                    rx_byte_vld_d = 1'b1;
                    crc_d         = crc_upd;
                    len_d         = len_inc;
                    rxer_d        = rxer_q | RX_ER;
                end
            end
            ST_DROP: begin
                if (!RX_DV) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A held low nibble at end of frame is neither emitted nor counted
        if (end_frame) begin
            state_d            = ST_IDLE;
            frame_done_d       = 1'b1;
            frame_len_d        = len_q;
            status_d.crc_err   = (crc_q != CRC_RESIDUE);
            status_d.align_err = end_odd;
            status_d.rxer_seen = rxer_q;
            status_d.runt      = (len_q < LEN_W'(MIN_LEN));
            status_d.too_long  = (len_q > LEN_W'(MAX_LEN));
            frame_ok_d         = ~|status_d;
        end
    end

    always_ff @(posedge RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            lo_nib_q    <= '0;
            rxer_q      <= 1'b0;
            rx_byte     <= '0;
            rx_byte_vld <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_len   <= '0;
            status_q    <= '0;
            pre_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            lo_nib_q    <= lo_nib_d;
            rxer_q      <= rxer_d;
            rx_byte     <= rx_byte_d;
            rx_byte_vld <= rx_byte_vld_d;
            frame_done  <= frame_done_d;
            frame_ok    <= frame_ok_d;
            frame_len   <= frame_len_d;
            status_q    <= status_d;
            pre_err     <= pre_err_d;
        end
    end

    assign crc_err   = status_q.crc_err;
    assign align_err = status_q.align_err;
    assign rxer_seen = status_q.rxer_seen;
    assign runt      = status_q.runt;
    assign too_long  = status_q.too_long;

endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// Directed bench for mii_rx_frame_checker: table of frame scenarios plus
// hand-written reset-in-frame and back-to-back sequences.
module tb_mii_rx_frame_checker;

    logic        RX_CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        RX_DV = 1'b0;
    logic        RX_ER = 1'b0;
    logic [3:0]  RXD = 4'h0;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld, frame_done, frame_ok, crc_err, align_err;
    logic        rxer_seen, runt, too_long, pre_err;
    logic [15:0] frame_len;

    mii_rx_frame_checker dut (
        .RX_CLK      (RX_CLK),
        .reset_n     (reset_n),
        .RX_DV       (RX_DV),
        .RX_ER       (RX_ER),
        .RXD         (RXD),
        .rx_byte     (rx_byte),
        .rx_byte_vld (rx_byte_vld),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .align_err   (align_err),
        .rxer_seen   (rxer_seen),
        .runt        (runt),
        .too_long    (too_long),
        .frame_len   (frame_len),
        .pre_err     (pre_err)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        int len;        // bytes DA..FCS
        int flip_byte;  // -1: none
        int extra_nib;  // 1: one trailing nibble
        int er_byte;    // -1: none
        int pre_kind;   // 0 normal, 1 preamble 5,5,7, 2 DV drop after five 5s
        int exp_done;
        int exp_vld;
        int exp_pre;
        int exp_ok;
        int exp_crc;
        int exp_align;
        int exp_rxer;
        int exp_runt;
        int exp_long;
        int exp_len;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0, done_cnt = 0, ok_cnt = 0, pre_cnt = 0;
    int cap_ok, cap_crc, cap_align, cap_rxer, cap_runt, cap_long, cap_len;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    vec_t vecs[10];

    always @(negedge RX_CLK) begin
        if (rx_byte_vld) begin
            vld_cnt++;
            rx_q.push_back(rx_byte);
        end
        if (frame_done) begin
            done_cnt++;
            if (frame_ok) ok_cnt++;
            cap_ok    = int'(frame_ok);
            cap_crc   = int'(crc_err);
            cap_align = int'(align_err);
            cap_rxer  = int'(rxer_seen);
            cap_runt  = int'(runt);
            cap_long  = int'(too_long);
            cap_len   = int'(frame_len);
        end
        if (pre_err) pre_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        RX_DV = dv;
        RX_ER = er;
        RXD   = d;
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic build_frame(input int len, input int flip_byte);
        logic [31:0] fcs;
        logic [7:0]  b;
        tx_q.delete();
        for (int i = 0; i < len - 4; i++) tx_q.push_back(8'(i * 7 + 3));
        fcs = ~crc_model(tx_q);
        for (int k = 0; k < 4; k++) tx_q.push_back(fcs[8*k +: 8]);
        if (flip_byte >= 0) begin
            b = tx_q[flip_byte];
            b[0] = ~b[0];
            tx_q[flip_byte] = b;
        end
    endtask

    task automatic send_frame(input vec_t v, input int idle);
        logic [7:0] b;
        if (v.len >= 4) build_frame(v.len, v.flip_byte);
        else tx_q.delete();
        rx_q.delete();
        case (v.pre_kind)
            1: begin
                nib(1'b1, 1'b0, 4'h5);
                nib(1'b1, 1'b0, 4'h5);
                nib(1'b1, 1'b0, 4'h7);
                nib(1'b1, 1'b0, 4'hD);
            end
            2: repeat (5) nib(1'b1, 1'b0, 4'h5);
            default: begin
                repeat (15) nib(1'b1, 1'b0, 4'h5);
                nib(1'b1, 1'b0, 4'hD);
            end
        endcase
        if (v.pre_kind != 2) begin
            foreach (tx_q[i]) begin
                b = tx_q[i];
                nib(1'b1, (i == v.er_byte), b[3:0]);
                nib(1'b1, 1'b0, b[7:4]);
            end
            if (v.extra_nib != 0) nib(1'b1, 1'b0, 4'hA);
        end
        repeat (idle) nib(1'b0, 1'b0, 4'h0);
    endtask

    task automatic check_bytes(input string name);
        int bad = 0;
        if (rx_q.size() != tx_q.size()) bad++;
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++) begin
            if (rx_q[i] != tx_q[i]) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int d0, v0, p0, o0;
        vec_t good;

        //          len  flip ext  er  pk  done vld   pre ok crc al rx runt long len
        vecs[0] = '{64,   -1, 0,  -1, 0,  1,   64,   0,  1, 0,  0, 0, 0,   0,   64};
        vecs[1] = '{64,   20, 0,  -1, 0,  1,   64,   0,  0, 1,  0, 0, 0,   0,   64};
        vecs[2] = '{64,   -1, 1,  -1, 0,  1,   64,   0,  0, 1,  1, 0, 0,   0,   64};
        vecs[3] = '{64,   -1, 0,  30, 0,  1,   64,   0,  0, 0,  0, 1, 0,   0,   64};
        vecs[4] = '{40,   -1, 0,  -1, 0,  1,   40,   0,  0, 0,  0, 0, 1,   0,   40};
        vecs[5] = '{63,   -1, 0,  -1, 0,  1,   63,   0,  0, 0,  0, 0, 1,   0,   63};
        vecs[6] = '{1522, -1, 0,  -1, 0,  1,   1522, 0,  1, 0,  0, 0, 0,   0,   1522};
        vecs[7] = '{1523, -1, 0,  -1, 0,  1,   1523, 0,  0, 0,  0, 0, 0,   1,   1523};
        vecs[8] = '{64,   -1, 0,  -1, 1,  0,   0,    1,  0, 0,  0, 0, 0,   0,   0};
        vecs[9] = '{0,    -1, 0,  -1, 2,  0,   0,    1,  0, 0,  0, 0, 0,   0,   0};
        good = vecs[0];

        repeat (3) @(posedge RX_CLK);
        #1;
        check("reset_outs", int'({rx_byte, rx_byte_vld, frame_done, frame_ok, crc_err,
                                  align_err, rxer_seen, runt, too_long, pre_err}), 0);
        check("reset_len", int'(frame_len), 0);
        reset_n = 1'b1;
        repeat (3) nib(1'b0, 1'b0, 4'h0);
        check("idle_outs", int'({rx_byte_vld, frame_done, frame_ok, pre_err}), 0);

        for (int n = 0; n < 10; n++) begin
            d0 = done_cnt; v0 = vld_cnt; p0 = pre_cnt;
            send_frame(vecs[n], 8);
            check($sformatf("v%0d_done", n), done_cnt - d0, vecs[n].exp_done);
            check($sformatf("v%0d_vld", n), vld_cnt - v0, vecs[n].exp_vld);
            check($sformatf("v%0d_pre", n), pre_cnt - p0, vecs[n].exp_pre);
            if (vecs[n].exp_vld > 0) check_bytes($sformatf("v%0d_bytes", n));
            if (vecs[n].exp_done > 0) begin
                check($sformatf("v%0d_ok", n), cap_ok, vecs[n].exp_ok);
                check($sformatf("v%0d_crc", n), cap_crc, vecs[n].exp_crc);
                check($sformatf("v%0d_align", n), cap_align, vecs[n].exp_align);
                check($sformatf("v%0d_rxer", n), cap_rxer, vecs[n].exp_rxer);
                check($sformatf("v%0d_runt", n), cap_runt, vecs[n].exp_runt);
                check($sformatf("v%0d_long", n), cap_long, vecs[n].exp_long);
                check($sformatf("v%0d_len", n), cap_len, vecs[n].exp_len);
            end
        end

        // Reset in the middle of a frame, just after byte 9's high nibble
        d0 = done_cnt;
        build_frame(64, -1);
        repeat (15) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 10; i++) begin
            nib(1'b1, 1'b0, tx_q[i][3:0]);
            nib(1'b1, 1'b0, tx_q[i][7:4]);
        end
        check("pre_rst_vld", int'(rx_byte_vld), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_outs", int'({rx_byte, rx_byte_vld, frame_done, frame_ok, crc_err,
                                    align_err, rxer_seen, runt, too_long, pre_err}), 0);
        check("mid_rst_len", int'(frame_len), 0);
        repeat (3) nib(1'b0, 1'b0, 4'h0);
        reset_n = 1'b1;
        repeat (8) nib(1'b0, 1'b0, 4'h0);
        check("mid_rst_no_done", done_cnt - d0, 0);

        // Back-to-back: second preamble sampled in the first frame_done cycle
        d0 = done_cnt; o0 = ok_cnt; v0 = vld_cnt;
        send_frame(good, 1);
        send_frame(good, 8);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_ok", ok_cnt - o0, 2);
        check("b2b_vld", vld_cnt - v0, 128);
        check("b2b_len", cap_len, 64);
        check_bytes("b2b_bytes");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
